// File: rtl/cpu_muldiv_unit.sv
// ---------------------------------------------------------------------------
// cpu_muldiv_unit
//
// Iterative multiply/divide unit holding the MIPS HI/LO registers. Operands
// come straight from the register-file read ports; HI/LO feed MFHI/MFLO.
// A mul/div takes ITER clocks of shift-add / restoring-divide iteration
// plus one fix-up clock (sign correction and HI/LO write), so the result
// is visible 33 clocks after acceptance for XLEN=32.
//
// Optional feature: define MULDIV_MADD_EN to enable MADDU/MADD (op 110/111),
// which add the product into the pre-op {hi,lo}. Without it those opcodes
// are ignored.
//
// Ports:
//   clk      in   clock, rising edge
//   reset    in   asynchronous, active-low reset
//   start    in   issue op this cycle (taken only when idle and not flushed)
//   op       in   000 MULTU 001 MULT 010 DIVU 011 DIV 100 MTHI 101 MTLO
//                 110 MADDU 111 MADD
//   rs_data  in   operand A (multiplicand / dividend / MT source)
//   rt_data  in   operand B (multiplier / divisor)
//   flush    in   synchronous abort of the in-flight op
//   busy     out  mul/div in flight; control stalls dependent instructions
//   done     out  one-cycle pulse after HI/LO were written by a mul/div
//   hi, lo   out  HI / LO registers
// ---------------------------------------------------------------------------
module cpu_muldiv_unit #(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs_data,
    input  logic [XLEN-1:0] rt_data,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    localparam int            CW       = $clog2(ITER);
    localparam logic [CW-1:0] CNT_LAST = CW'(ITER - 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2*XLEN-1:0]   prod_q, prod_d;     // product, or {unused, dividend/quotient}
    logic [XLEN-1:0]     rem_q, rem_d;       // divide partial remainder
    logic [XLEN-1:0]     b_q, b_d;           // multiplicand / divisor magnitude
    logic                neg_q, neg_d;       // negate product / quotient in FIX
    logic                rem_neg_q, rem_neg_d;
    logic                div0_q, div0_d;
    logic                is_div_q, is_div_d;
    logic [XLEN-1:0]     hi_q, hi_d;
    logic [XLEN-1:0]     lo_q, lo_d;
    logic                done_q, done_d;
`ifdef MULDIV_MADD_EN
    logic                madd_q, madd_d;
`endif

    // ---------------- op decode / acceptance ----------------
    logic op_is_mt, op_is_div, op_is_calc, accept;
    logic a_neg, b_neg;
    logic [XLEN-1:0] mag_a, mag_b;

    assign op_is_mt  = (op[2:1] == 2'b10);
    assign op_is_div = (op[2:1] == 2'b01);
`ifdef MULDIV_MADD_EN
    assign op_is_calc = (op[2:1] != 2'b10);
`else
    assign op_is_calc = (op[2:1] == 2'b00) || op_is_div;
`endif
    assign accept = start && (state_q == S_IDLE) && !flush;

    // op[0] selects the signed variant for every mul/div/madd opcode.
    assign a_neg = op[0] && rs_data[XLEN-1];
    assign b_neg = op[0] && rt_data[XLEN-1];
    assign mag_a = a_neg ? -rs_data : rs_data;
    assign mag_b = b_neg ? -rt_data : rt_data;

    // ---------------- iteration datapath ----------------
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     rem_shift;
    logic              div_ge;
    logic [XLEN-1:0]   div_diff;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix;

    assign mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]}
                     + {1'b0, (prod_q[0] ? b_q : {XLEN{1'b0}})};
    assign rem_shift = {rem_q, prod_q[XLEN-1]};
    assign div_ge    = (rem_shift >= {1'b0, b_q});
    // Only used when div_ge, where the true difference fits in XLEN bits.
    assign div_diff  = rem_shift[XLEN-1:0] - b_q;

    assign prod_fix  = neg_q ? -prod_q : prod_q;
    // A zero divisor leaves the dividend as remainder and all-ones quotient;
    // forcing the quotient keeps signed divide-by-zero identical to unsigned.
    assign quo_fix   = div0_q ? {XLEN{1'b1}}
                              : (neg_q ? -prod_q[XLEN-1:0] : prod_q[XLEN-1:0]);
    assign rem_fix   = rem_neg_q ? -rem_q : rem_q;

    // ---------------- state register ----------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            prod_q    <= '0;
            rem_q     <= '0;
            b_q       <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            div0_q    <= 1'b0;
            is_div_q  <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
`ifdef MULDIV_MADD_EN
            madd_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            prod_q    <= prod_d;
            rem_q     <= rem_d;
            b_q       <= b_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            div0_q    <= div0_d;
            is_div_q  <= is_div_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
`ifdef MULDIV_MADD_EN
            madd_q    <= madd_d;
`endif
        end
    end

    // ---------------- next-state logic ----------------
    // NOTE: every signal written in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: if (accept && op_is_calc)  state_d = S_CALC;
                S_CALC: if (cnt_q == CNT_LAST)     state_d = S_FIX;
                S_FIX:                             state_d = S_IDLE;
                default:                           state_d = S_IDLE;
            endcase
        end
    end

    // ---------------- datapath next values ----------------
    always_comb begin
        cnt_d     = cnt_q;
        prod_d    = prod_q;
        rem_d     = rem_q;
        b_d       = b_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        div0_d    = div0_q;
        is_div_d  = is_div_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
`ifdef MULDIV_MADD_EN
        madd_d    = madd_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (accept && op_is_mt) begin
                    if (op[0]) lo_d = rs_data;
                    else       hi_d = rs_data;
                end else if (accept && op_is_calc) begin
                    cnt_d     = '0;
                    rem_d     = '0;
                    neg_d     = a_neg ^ b_neg;
                    rem_neg_d = a_neg;
                    div0_d    = (rt_data == '0);
                    is_div_d  = op_is_div;
`ifdef MULDIV_MADD_EN
                    madd_d    = op[2];
`endif
                    if (op_is_div) begin
                        prod_d = {{XLEN{1'b0}}, mag_a};
                        b_d    = mag_b;
                    end else begin
                        prod_d = {{XLEN{1'b0}}, mag_b};
                        b_d    = mag_a;
                    end
                end
            end
            S_CALC: begin
                cnt_d = cnt_q + CW'(1);
                if (is_div_q) begin
                    rem_d              = div_ge ? div_diff : rem_shift[XLEN-1:0];
                    prod_d[XLEN-1:0]   = {prod_q[XLEN-2:0], div_ge};
                end else begin
                    // Add multiplicand into the upper half when the current
                    // multiplier bit is set, then shift the whole register.
                    prod_d = {mul_sum, prod_q[XLEN-1:1]};
                end
            end
            S_FIX: begin
                if (!flush) begin
                    done_d = 1'b1;
                    if (is_div_q) begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end else begin
`ifdef MULDIV_MADD_EN
                        if (madd_q) {hi_d, lo_d} = {hi_q, lo_q} + prod_fix;
                        else        {hi_d, lo_d} = prod_fix;
`else
                        {hi_d, lo_d} = prod_fix;
`endif
                    end
                end
            end
            default: ;
        endcase
    end

    // ---------------- outputs ----------------
    always_comb begin
        busy = (state_q != S_IDLE);
        done = done_q;
        hi   = hi_q;
        lo   = lo_q;
    end

endmodule

// File: tb/tb_cpu_muldiv_unit.sv
module tb_cpu_muldiv_unit;

    localparam logic [2:0] OP_MULTU = 3'b000;
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_DIVU  = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam logic [2:0] OP_MADDU = 3'b110;
    localparam logic [2:0] OP_MADD  = 3'b111;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_data, rt_data;
    logic        flush;
    logic        busy, done;
    logic [31:0] hi, lo;

    int errors = 0;
    int checks = 0;
    logic [31:0] m_hi, m_lo;   // reference HI/LO

    always #5 clk = ~clk;

    cpu_muldiv_unit #(.XLEN(32), .ITER(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .flush   (flush),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    // Architectural result of an op, from plain integer arithmetic.
    function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] a,
                                               input logic [31:0] b, input logic [63:0] acc);
        longint      sa, sb, q, r;
        logic [63:0] ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (o)
            OP_MULTU: return ua * ub;
            OP_MULT:  return 64'(sa * sb);
            OP_DIVU:  if (b == 0) return {a, 32'hFFFF_FFFF};
                      else        return {a % b, a / b};
            OP_DIV:   begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            OP_MADDU: return acc + ua * ub;
            OP_MADD:  return acc + 64'(sa * sb);
            default:  return acc;
        endcase
    endfunction

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        op = o; rs_data = a; rt_data = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at the first negedge after acceptance; returns at the done cycle.
    task automatic wait_result(input string name, input logic [63:0] exp);
        int n = 1;
        int busy_cnt = 0;
        bit seen = 0;
        while (n <= 40 && !seen) begin
            if (done === 1'b1) seen = 1;
            else begin
                if (busy === 1'b1) busy_cnt++;
                @(negedge clk);
                n++;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s timeout: no done within 40 cycles", name);
        end else begin
            checks++;
            if (n - 1 !== 33) begin
                errors++;
                $display("FAIL %s latency: got %0d edges, expected 33", name, n - 1);
            end
            checks++;
            if (busy_cnt !== 33) begin
                errors++;
                $display("FAIL %s busy cycles: got %0d, expected 33", name, busy_cnt);
            end
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL %s busy in done cycle: got %b, expected 0", name, busy);
            end
        end
        checks++;
        if (hi !== exp[63:32]) begin
            errors++;
            $display("FAIL %s hi: got %h, expected %h", name, hi, exp[63:32]);
        end
        checks++;
        if (lo !== exp[31:0]) begin
            errors++;
            $display("FAIL %s lo: got %h, expected %h", name, lo, exp[31:0]);
        end
        {m_hi, m_lo} = exp;
    endtask

    task automatic run_op(input string name, input logic [2:0] o,
                          input logic [31:0] a, input logic [31:0] b);
        logic [63:0] exp;
        exp = ref_result(o, a, b, {m_hi, m_lo});
        issue(o, a, b);
        wait_result(name, exp);
    endtask

    task automatic check_hilo(input string name);
        checks++;
        if (hi !== m_hi) begin
            errors++;
            $display("FAIL %s hi: got %h, expected %h", name, hi, m_hi);
        end
        checks++;
        if (lo !== m_lo) begin
            errors++;
            $display("FAIL %s lo: got %h, expected %h", name, lo, m_lo);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; flush = 1'b0; op = '0; rs_data = '0; rt_data = '0;
        #12;
        m_hi = '0; m_lo = '0;
        check_hilo("reset");
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset busy/done: got %b/%b, expected 0/0", busy, done);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_mt();
        @(negedge clk);
        op = OP_MTHI; rs_data = 32'hAAAA_5555; start = 1'b1;
        @(negedge clk);
        m_hi = 32'hAAAA_5555;
        check_hilo("mthi");
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL mthi busy: got %b, expected 0", busy);
        end
        op = OP_MTLO; rs_data = 32'h0000_BEEF;
        @(negedge clk);
        start = 1'b0;
        m_lo = 32'h0000_BEEF;
        check_hilo("mtlo");
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL mtlo busy/done: got %b/%b, expected 0/0", busy, done);
        end
    endtask

    task automatic test_directed();
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_result("multu_max", 64'hFFFF_FFFE_0000_0001);
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL done pulse width: got %b one cycle later, expected 0", done);
        end
        issue(OP_MULT, 32'hFFFF_FFFD, 32'd7);
        wait_result("mult_neg", 64'hFFFF_FFFF_FFFF_FFEB);
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_result("div_neg", 64'hFFFF_FFFF_FFFF_FFFD);
        issue(OP_DIVU, 32'h1234_5678, 32'd0);
        wait_result("divu_zero", 64'h1234_5678_FFFF_FFFF);
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_result("div_ovf", 64'h0000_0000_8000_0000);
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd0);
        wait_result("div_zero_neg", 64'hFFFF_FFF9_FFFF_FFFF);
    endtask

    task automatic test_flush();
        int bad = 0;
        issue(OP_DIVU, 32'h1234_5678, 32'd3);       // now at cycle 1
        repeat (4) @(negedge clk);                  // cycle 5
        op = OP_MULTU; rs_data = 32'd9; rt_data = 32'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL flush busy mid-op: got %b, expected 1", busy);
        end
        repeat (4) @(negedge clk);                  // cycle 10
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL flush busy: got %b, expected 0", busy);
        end
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1 || busy === 1'b1) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL flush aftermath: %0d cycles with busy/done, expected 0", bad);
        end
        check_hilo("flush_hilo");
        op = OP_MTHI; rs_data = 32'h1357_2468; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check_hilo("flush_vs_start");
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b;
        logic [63:0] exp;
        a = $urandom; b = $urandom;
        run_op("b2b_first", OP_MULT, a, b);
        a = $urandom; b = $urandom_range(1, 1000);
        exp = ref_result(OP_DIVU, a, b, {m_hi, m_lo});
        op = OP_DIVU; rs_data = a; rt_data = b; start = 1'b1;  // in the done cycle
        @(negedge clk);
        start = 1'b0;
        wait_result("b2b_second", exp);
    endtask

    task automatic test_madd();
        issue(OP_MTHI, 32'h0, 32'h0);
        issue(OP_MTLO, 32'hFFFF_FFFF, 32'h0);
        m_hi = 32'h0; m_lo = 32'hFFFF_FFFF;
        check_hilo("madd_setup");
`ifdef MULDIV_MADD_EN
        issue(OP_MADDU, 32'd1, 32'd1);
        wait_result("maddu_carry", 64'h0000_0001_0000_0000);
        run_op("madd_signed", OP_MADD, 32'hFFFF_FFFE, 32'd5);
`else
        begin
            int bad = 0;
            issue(OP_MADDU, 32'd1, 32'd1);
            for (int i = 0; i < 40; i++) begin
                if (busy === 1'b1 || done === 1'b1) bad++;
                @(negedge clk);
            end
            checks++;
            if (bad !== 0) begin
                errors++;
                $display("FAIL madd disabled: %0d busy/done cycles, expected 0", bad);
            end
            check_hilo("madd_disabled");
        end
`endif
    endtask

    task automatic test_random();
        logic [2:0]  o;
        logic [31:0] a, b;
        for (int i = 0; i < 30; i++) begin
`ifdef MULDIV_MADD_EN
            o = 3'($urandom_range(0, 5));
            if (o >= 3'd4) o = o + 3'd2;
`else
            o = 3'($urandom_range(0, 3));
`endif
            case ($urandom_range(0, 3))
                0: begin a = $urandom; b = $urandom; end
                1: begin a = 32'($signed(-100) + $signed($urandom_range(0, 200)));
                         b = 32'($signed(-20) + $signed($urandom_range(0, 40))); end
                2: begin a = $urandom; b = 32'h0; end
                default: begin a = ($urandom_range(0, 1) != 0) ? 32'h8000_0000 : 32'hFFFF_FFFF;
                               b = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : 32'h8000_0000; end
            endcase
            run_op("random", o, a, b);
        end
    endtask

    task automatic test_async_reset();
        issue(OP_MTHI, 32'hDEAD_BEEF, 32'h0);
        issue(OP_MULT, $urandom, $urandom);
        repeat (10) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        m_hi = '0; m_lo = '0;
        check_hilo("async_reset");
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL async_reset busy/done: got %b/%b, expected 0/0", busy, done);
        end
        @(negedge clk);
        reset = 1'b1;
        run_op("after_reset", OP_MULTU, 32'd12345, 32'd6789);
    endtask

    initial begin
        test_reset();
        test_mt();
        test_directed();
        test_flush();
        test_back_to_back();
        test_madd();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cpu_muldiv_unit.md
Name: cpu_muldiv_unit

Overview:
- Iterative multiply/divide unit with HI/LO registers for the MIPS CPU.
- Consumes the two register-file read operands (rs, rt) directly downstream of the register-file read ports.
- Produces HI/LO for MFHI/MFLO write-back.
- Multi-cycle: exposes busy so the control unit stalls the PC on MFHI/MFLO or a new mul/div while an operation is in flight.

Parameters:
- XLEN, 32, operand/HI/LO width (design verified only at 32).
- ITER, 32, iterations per mul/div; equals XLEN.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low; clears all state.
- start  input  1  issue op this cycle; accepted only when busy=0.
- op  input  3  000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 100 MTHI, 101 MTLO, 110 MADDU, 111 MADD.
- rs_data  input  32  operand A (multiplicand/dividend/MT source).
- rt_data  input  32  operand B (multiplier/divisor).
- flush  input  1  synchronous abort of in-flight op (exception/IRQ entry).
- busy  output  1  operation in progress; control must stall dependent instructions.
- done  output  1  one-cycle pulse when HI/LO are updated by a mul/div.
- hi  output  32  HI register.
- lo  output  32  LO register.

Behaviour:
- Reset (reset=0, async): state=IDLE; hi=0, lo=0, busy=0, done=0; internal counters and accumulators cleared. Reset mid-operation discards the op.
- States:
  - IDLE: waiting for start.
  - CALC: ITER iterations, one per clock.
  - FIX: sign correction and HI/LO write.
- Op acceptance: op accepted at edge E0 when start=1, busy=0, flush=0.
  - MTHI/MTLO: hi (or lo) <= rs_data at E0; no busy, no done; stays in IDLE.
  - Mul/div: latch the magnitudes of rs/rt (signed ops only) and the result sign bits; go to CALC; busy=1 from after E0.
- CALC:
  - Multiply: shift-add on 64-bit product register.
  - Divide: restoring, one quotient bit per cycle; 33-bit partial remainder.
  - Counter runs 0..ITER-1, then FIX.
- FIX, at E(ITER+1) = E33 for 32-bit:
  - Negate the product, quotient or remainder as required, then write hi/lo.
  - Go to IDLE; busy=0 and done=1 for exactly the cycle following E33.
  - Total: 33 clocks from acceptance to visible result.
- Result rules:
  - MULT/MULTU: {hi,lo} = 64-bit product, two's complement for MULT.
  - DIV/DIVU: lo = quotient, hi = remainder.
  - Signed divide: quotient truncates toward zero; remainder takes the dividend's sign.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0; no trap.
  - Divide by zero, signed or unsigned: lo=0xFFFFFFFF, hi=rs_data; no trap.
- start while busy=1: ignored, no queuing; control must hold the instruction via stall.
- flush=1 in any cycle: returns to IDLE next edge; hi/lo keep their pre-op values; no done. flush and start in the same cycle: flush wins, op not accepted.
- Back-to-back: a start in the done cycle is accepted (busy=0 then).
- hi/lo are registered outputs, stable except on MT writes and FIX.

Optional Feature:
- Macro MULDIV_MADD_EN.
- Defined: op 110/111 perform MADDU/MADD, {hi,lo} <= {hi,lo} + product, added in FIX using the pre-op HI/LO. Same 33-clock latency, 64-bit wrap-around on overflow.
- Undefined: op 110/111 are treated as no-ops: not accepted, busy stays 0, hi/lo unchanged.

Test Plan:
- MULTU rs=0xFFFFFFFF rt=0xFFFFFFFF -> done one cycle after E33; hi=0xFFFFFFFE, lo=0x00000001; busy high for 33 cycles.
- MULT rs=0xFFFFFFFD(-3) rt=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then DIV rs=0xFFFFFFF9(-7) rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU rs=0x12345678 rt=0 -> lo=0xFFFFFFFF, hi=0x12345678. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI 0xAAAA5555 then MTLO 0x0000BEEF on consecutive cycles -> hi/lo updated the edge after each issue; busy never asserted.
- DIVU issued, second start at cycle 5 ignored, flush at cycle 10 -> busy drops next cycle, no done, hi/lo unchanged. Reset pulse mid-MULT -> hi=lo=0 immediately, asynchronously.
- With MULDIV_MADD_EN: hi=0, lo=0xFFFFFFFF, MADDU rs=1 rt=1 -> hi=1, lo=0. Without the macro: same stimulus -> busy=0, hi/lo unchanged.
